// File: rtl/enemy_missile_spawn_gen.sv
`default_nettype none
// ============================================================================
// Module      : enemy_missile_spawn_gen
// Description : Tick-driven rotate/LFSR launch pattern with per-channel taps,
//               holdoff and per-wave spawn budget.
// Revision    : 1.0 - initial release
// ============================================================================
module enemy_missile_spawn_gen #(
  parameter int               DEPTH      = 16,
  parameter int               CHANNELS   = 4,
  parameter logic [DEPTH-1:0] SEED       = 16'h2221,
  parameter logic [DEPTH-1:0] LFSR_TAPS  = 16'hB400,
  parameter int               HOLDOFF    = 0,
  parameter int               MAX_SPAWNS = 8,
  parameter int               TAPW       = $clog2(DEPTH),
  parameter int               CNTW       = $clog2(MAX_SPAWNS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     mode,
  input  logic                     load,
  input  logic [DEPTH-1:0]         load_data,
  input  logic [CHANNELS*TAPW-1:0] tap_sel,
  output logic [CHANNELS-1:0]      spawn,
  output logic [CNTW-1:0]          spawn_count,
  output logic                     wave_done
);

  localparam int              c_hw      = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [CNTW-1:0] c_max_cnt = CNTW'(MAX_SPAWNS);
  localparam logic [c_hw-1:0] c_holdoff = c_hw'(HOLDOFF);

  logic [DEPTH-1:0]    r_s;
  logic [DEPTH-1:0]    w_s_next;
  logic [c_hw-1:0]     r_h      [CHANNELS];
  logic [c_hw-1:0]     w_h_next [CHANNELS];
  logic [CHANNELS-1:0] r_spawn;
  logic [CHANNELS-1:0] w_fire;
  logic [CHANNELS-1:0] w_cand;
  logic [CNTW-1:0]     r_cnt;
  logic [CNTW-1:0]     w_cnt_next;
  logic                r_done;

  always_comb begin
    w_s_next   = r_s;
    w_cnt_next = r_cnt;
    w_fire     = '0;
    w_cand     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_h_next[c] = r_h[c];
      // Tap indices that name no pattern bit leave the candidate at zero.
      for (int i = 0; i < DEPTH; i++) begin
        if (tap_sel[c*TAPW +: TAPW] == TAPW'(i)) begin
          w_cand[c] = r_s[i];
        end
      end
    end

    if (tick) begin
      if (mode && (r_s == '0)) begin
        w_s_next = SEED;
      end else begin
        w_s_next = {(mode ? ^(r_s & LFSR_TAPS) : r_s[0]), r_s[DEPTH-1:1]};
      end

      // Lower channels claim the remaining budget first.
      for (int c = 0; c < CHANNELS; c++) begin
        if (r_h[c] != '0) begin
          w_h_next[c] = r_h[c] - 1'b1;
        end else if (w_cand[c] && (w_cnt_next < c_max_cnt)) begin
          w_fire[c]   = 1'b1;
          w_cnt_next  = w_cnt_next + 1'b1;
          w_h_next[c] = c_holdoff;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s     <= SEED;
      r_spawn <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_h[c] <= '0;
      end
    end else if (load) begin
      r_s     <= load_data;
      r_spawn <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_h[c] <= '0;
      end
    end else begin
      r_s     <= w_s_next;
      r_spawn <= w_fire;
      r_cnt   <= w_cnt_next;
      r_done  <= (w_cnt_next == c_max_cnt);
      for (int c = 0; c < CHANNELS; c++) begin
        r_h[c] <= w_h_next[c];
      end
    end
  end

  assign spawn       = r_spawn;
  assign spawn_count = r_cnt;
  assign wave_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_enemy_missile_spawn_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_enemy_missile_spawn_gen
// Description : Self-checking bench: table vectors, directed corner cases and
//               random traffic against a reference model, four configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_missile_spawn_gen;

  localparam logic [15:0] SEED = 16'h2221;
  localparam logic [15:0] TAPS = 16'hB400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        mode = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_data = '0;
  logic [15:0] tap_sel = '0;

  logic       spawn_a, done_a, spawn_h, done_h, done_b, done_d;
  logic [3:0] cnt_a, cnt_h, cnt_d, spawn_b, spawn_d;
  logic [1:0] cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  enemy_missile_spawn_gen #(.CHANNELS(1)) u_a (
    .clk(clk), .rst(rst), .tick(tick), .mode(mode), .load(load),
    .load_data(load_data), .tap_sel(tap_sel[3:0]),
    .spawn(spawn_a), .spawn_count(cnt_a), .wave_done(done_a));

  enemy_missile_spawn_gen #(.CHANNELS(1), .HOLDOFF(4)) u_h (
    .clk(clk), .rst(rst), .tick(tick), .mode(mode), .load(load),
    .load_data(load_data), .tap_sel(tap_sel[3:0]),
    .spawn(spawn_h), .spawn_count(cnt_h), .wave_done(done_h));

  enemy_missile_spawn_gen #(.MAX_SPAWNS(3)) u_b (
    .clk(clk), .rst(rst), .tick(tick), .mode(mode), .load(load),
    .load_data(load_data), .tap_sel(tap_sel),
    .spawn(spawn_b), .spawn_count(cnt_b), .wave_done(done_b));

  enemy_missile_spawn_gen u_d (
    .clk(clk), .rst(rst), .tick(tick), .mode(mode), .load(load),
    .load_data(load_data), .tap_sel(tap_sel),
    .spawn(spawn_d), .spawn_count(cnt_d), .wave_done(done_d));

  // Reference model state: pattern as a plain 16-bit word, holdoffs and count as integers.
  typedef struct packed {
    logic [15:0]     s;
    logic [3:0][7:0] h;
    logic [7:0]      cnt;
    logic            done;
    logic [3:0]      sp;
  } ms_t;

  ms_t m_a, m_h, m_b, m_d;

  function automatic ms_t m_reset();
    ms_t r;
    r = '0;
    r.s = SEED;
    return r;
  endfunction

  function automatic ms_t m_step(ms_t m, int nch, int hold, int maxs);
    ms_t n;
    logic fb;
    n = m;
    n.sp = '0;
    if (load) begin
      n = '0;
      n.s = load_data;
      return n;
    end
    if (!tick) return n;
    for (int c = 0; c < nch; c++) begin
      int idx;
      idx = int'(tap_sel[c*4 +: 4]);
      if (m.h[c] != 0) begin
        n.h[c] = m.h[c] - 8'd1;
      end else if (m.s[idx] && (int'(n.cnt) < maxs)) begin
        n.sp[c] = 1'b1;
        n.cnt   = n.cnt + 8'd1;
        n.h[c]  = 8'(hold);
      end
    end
    if (mode && (m.s == 16'd0)) begin
      n.s = SEED;
    end else begin
      fb  = mode ? ^(m.s & TAPS) : m.s[0];
      n.s = 16'((int'(m.s) / 2) + (fb ? 32768 : 0));
    end
    n.done = (int'(n.cnt) == maxs);
    return n;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    m_a = m_step(m_a, 1, 0, 8);
    m_h = m_step(m_h, 1, 4, 8);
    m_b = m_step(m_b, 4, 0, 3);
    m_d = m_step(m_d, 4, 0, 8);
    chk("model_a_spawn", int'(spawn_a), int'(m_a.sp[0]));
    chk("model_a_count", int'(cnt_a), int'(m_a.cnt));
    chk("model_a_done",  int'(done_a), int'(m_a.done));
    chk("model_h_spawn", int'(spawn_h), int'(m_h.sp[0]));
    chk("model_h_count", int'(cnt_h), int'(m_h.cnt));
    chk("model_h_done",  int'(done_h), int'(m_h.done));
    chk("model_b_spawn", int'(spawn_b), int'(m_b.sp));
    chk("model_b_count", int'(cnt_b), int'(m_b.cnt));
    chk("model_b_done",  int'(done_b), int'(m_b.done));
    chk("model_d_spawn", int'(spawn_d), int'(m_d.sp));
    chk("model_d_count", int'(cnt_d), int'(m_d.cnt));
    chk("model_d_done",  int'(done_d), int'(m_d.done));
  endtask

  task automatic reset_models();
    m_a = m_reset();
    m_h = m_reset();
    m_b = m_reset();
    m_d = m_reset();
  endtask

  typedef struct packed {
    logic       exp_a;
    logic [7:0] cnt_a;
    logic       done_a;
    logic       exp_h;
    logic [7:0] cnt_h;
  } vec_t;

  vec_t vec [32];

  initial begin
    int ca, chh;
    logic fa, fh;
    // Rotate from SEED with ch0 on tap 12: bit 13,0,5,9 reach tap 12 on ticks 1,4,9,13.
    ca = 0;
    chh = 0;
    for (int k = 0; k < 32; k++) begin
      fa = ((k % 16) == 1) || ((k % 16) == 4) || ((k % 16) == 9) || ((k % 16) == 13);
      fh = (k == 1) || (k == 9) || (k == 17) || (k == 25);
      if (fa) ca++;
      if (fh) chh++;
      vec[k].exp_a  = fa;
      vec[k].cnt_a  = 8'(ca);
      vec[k].done_a = (ca == 8);
      vec[k].exp_h  = fh;
      vec[k].cnt_h  = 8'(chh);
    end

    reset_models();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst_spawn_d", int'(spawn_d), 0);
    chk("rst_count_d", int'(cnt_d), 0);
    chk("rst_done_d",  int'(done_d), 0);
    chk("rst_spawn_b", int'(spawn_b), 0);

    // Table-driven rotate sequence, ticking every cycle.
    tick = 1'b1;
    mode = 1'b0;
    tap_sel = 16'h000C;
    for (int k = 0; k < 32; k++) begin
      cyc();
      chk("tbl_a_spawn", int'(spawn_a), int'(vec[k].exp_a));
      chk("tbl_a_count", int'(cnt_a), int'(vec[k].cnt_a));
      chk("tbl_a_done",  int'(done_a), int'(vec[k].done_a));
      chk("tbl_h_spawn", int'(spawn_h), int'(vec[k].exp_h));
      chk("tbl_h_count", int'(cnt_h), int'(vec[k].cnt_h));
    end

    // LFSR zero guard: load zero with a simultaneous tick, then recover to SEED.
    mode = 1'b1;
    load = 1'b1;
    load_data = 16'h0000;
    tap_sel = 16'h0000;
    cyc();
    chk("zload_count", int'(cnt_d), 0);
    load = 1'b0;
    cyc();
    chk("zguard_spawn", int'(spawn_d), 0);
    cyc();
    chk("zrecover_spawn", int'(spawn_d), 15);
    chk("zrecover_count", int'(cnt_d), 4);
    cyc();

    // Load with tick mid-wave at spawn_count 5: no shift, wave restarts.
    mode = 1'b0;
    load = 1'b1;
    load_data = SEED;
    tick = 1'b0;
    cyc();
    load = 1'b0;
    tick = 1'b1;
    cyc();
    chk("mw_count4", int'(cnt_d), 4);
    tap_sel = 16'h1114;
    cyc();
    chk("mw_count5", int'(cnt_d), 5);
    load = 1'b1;
    load_data = 16'h0001;
    cyc();
    chk("lt_spawn", int'(spawn_d), 0);
    chk("lt_count", int'(cnt_d), 0);
    chk("lt_done",  int'(done_d), 0);
    load = 1'b0;
    tap_sel = 16'h0000;
    cyc();
    chk("lt_noshift_spawn", int'(spawn_d), 15);

    // Budget of 3 with four simultaneous candidates on tap 13.
    load = 1'b1;
    load_data = 16'h2000;
    tick = 1'b0;
    cyc();
    load = 1'b0;
    tick = 1'b1;
    tap_sel = 16'hDDDD;
    cyc();
    chk("bud_spawn", int'(spawn_b), 7);
    chk("bud_count", int'(cnt_b), 3);
    chk("bud_done",  int'(done_b), 1);
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk("bud_hold_spawn", int'(spawn_b), 0);
    end
    chk("bud_hold_done", int'(done_b), 1);

    // Asynchronous reset between clock edges mid-wave.
    #2 rst = 1'b1;
    #1;
    chk("arst_count_b", int'(cnt_b), 0);
    chk("arst_done_b",  int'(done_b), 0);
    chk("arst_count_d", int'(cnt_d), 0);
    chk("arst_count_a", int'(cnt_a), 0);
    #2 rst = 1'b0;
    reset_models();
    tap_sel = 16'h000C;
    cyc();
    chk("arst_k0_spawn", int'(spawn_a), 0);
    cyc();
    chk("arst_k1_spawn", int'(spawn_a), 1);
    chk("arst_k1_count", int'(cnt_a), 1);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      tick = ($urandom_range(0, 3) != 0);
      mode = $urandom_range(0, 1) == 1;
      load = ($urandom_range(0, 39) == 0);
      load_data = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 7) == 0) tap_sel = 16'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
